// File: rtl/itrace_commit_ring.sv
`default_nettype none
// ============================================================================
// Module   : itrace_commit_ring
// Purpose  : Keeps the last DEPTH retired instructions and, on halt, drains
//            them oldest-first over a valid/ready port.
// Revision : 1.0
// ============================================================================
module itrace_commit_ring #(
  parameter int DEPTH   = 16,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_commit_valid,
  input  logic [PC_W-1:0]          i_commit_pc,
  input  logic [INSTR_W-1:0]       i_commit_instr,
  input  logic                     i_halt,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [PC_W-1:0]          o_out_pc,
  output logic [INSTR_W-1:0]       o_out_instr,
  output logic [31:0]              o_out_seq,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [31:0]              o_overflow_cnt,
  output logic                     o_dump_done
);

  localparam int                 c_PTR_W   = $clog2(DEPTH);
  localparam int                 c_CNT_W   = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [31:0]        c_OVF_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_RECORD = 2'd0,
    ST_DUMP   = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t               r_state;
  logic [31:0]          r_mem_seq   [DEPTH];
  logic [PC_W-1:0]      r_mem_pc    [DEPTH];
  logic [INSTR_W-1:0]   r_mem_instr [DEPTH];
  logic [c_PTR_W-1:0]   r_wptr;
  logic [c_PTR_W-1:0]   r_rptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [31:0]          r_seq_cnt;
  logic [31:0]          r_ovf_cnt;
  logic                 r_dump_done;

  logic w_empty;
  logic w_full;
  logic w_rec_wr;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == c_FULL);
  assign w_rec_wr = (r_state == ST_RECORD) && i_commit_valid;

  // Storage needs no reset: entries are only ever shown while count is non-zero.
  always_ff @(posedge clk) begin
    if (w_rec_wr) begin
      r_mem_seq[r_wptr]   <= r_seq_cnt;
      r_mem_pc[r_wptr]    <= i_commit_pc;
      r_mem_instr[r_wptr] <= i_commit_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RECORD;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_seq_cnt   <= '0;
      r_ovf_cnt   <= '0;
      r_dump_done <= 1'b0;
    end else begin
      case (r_state)
        ST_RECORD: begin
          if (i_commit_valid) begin
            r_wptr    <= r_wptr + c_PTR_ONE;
            r_seq_cnt <= r_seq_cnt + 32'd1;
            if (w_full) begin
              // Ring full: the oldest entry is overwritten, so the read side advances too.
              r_rptr <= r_rptr + c_PTR_ONE;
              if (r_ovf_cnt != c_OVF_MAX) begin
                r_ovf_cnt <= r_ovf_cnt + 32'd1;
              end
            end else begin
              r_count <= r_count + c_CNT_ONE;
            end
          end
          if (i_halt) begin
            r_state <= ST_DUMP;
          end
        end
        ST_DUMP: begin
          if (w_empty) begin
            r_state     <= ST_DONE;
            r_dump_done <= 1'b1;
          end else if (i_out_ready) begin
            r_rptr  <= r_rptr + c_PTR_ONE;
            r_count <= r_count - c_CNT_ONE;
            if (r_count == c_CNT_ONE) begin
              r_state     <= ST_DONE;
              r_dump_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_dump_done <= 1'b1;
        end
        default: begin
          r_state <= ST_RECORD;
        end
      endcase
    end
  end

  assign o_out_valid    = (r_state == ST_DUMP) && !w_empty;
  assign o_out_pc       = w_empty ? '0 : r_mem_pc[r_rptr];
  assign o_out_instr    = w_empty ? '0 : r_mem_instr[r_rptr];
  assign o_out_seq      = w_empty ? '0 : r_mem_seq[r_rptr];
  assign o_count        = r_count;
  assign o_overflow_cnt = r_ovf_cnt;
  assign o_dump_done    = r_dump_done;

endmodule
`default_nettype wire

// File: tb/tb_itrace_commit_ring.sv
`default_nettype none
// ============================================================================
// Module   : tb_itrace_commit_ring
// Purpose  : Randomised scoreboard bench for itrace_commit_ring (DEPTH=4).
// Revision : 1.0
// ============================================================================
module tb_itrace_commit_ring;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_commit_valid;
  logic [31:0]       i_commit_pc;
  logic [31:0]       i_commit_instr;
  logic              i_halt;
  logic              i_out_ready;
  logic              o_out_valid;
  logic [31:0]       o_out_pc;
  logic [31:0]       o_out_instr;
  logic [31:0]       o_out_seq;
  logic [CNT_W-1:0]  o_count;
  logic [31:0]       o_overflow_cnt;
  logic              o_dump_done;

  itrace_commit_ring #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_commit_valid (i_commit_valid),
    .i_commit_pc    (i_commit_pc),
    .i_commit_instr (i_commit_instr),
    .i_halt         (i_halt),
    .o_out_valid    (o_out_valid),
    .i_out_ready    (i_out_ready),
    .o_out_pc       (o_out_pc),
    .o_out_instr    (o_out_instr),
    .o_out_seq      (o_out_seq),
    .o_count        (o_count),
    .o_overflow_cnt (o_overflow_cnt),
    .o_dump_done    (o_dump_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] instr;
  } beat_t;

  // Reference model: the ring is simply "the last DEPTH commits".
  beat_t           ring_q[$];
  beat_t           sb_q[$];
  int unsigned     m_seq;
  longint unsigned m_ovf;
  int              n_checks = 0;
  int              n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    ring_q.delete();
    sb_q.delete();
    m_seq = 0;
    m_ovf = 0;
  endtask

  task automatic model_commit(input logic [31:0] pc, input logic [31:0] instr);
    ring_q.push_back({m_seq, pc, instr});
    m_seq++;
    if (ring_q.size() > DEPTH) begin
      void'(ring_q.pop_front());
      if (m_ovf < 64'hFFFF_FFFF) m_ovf++;
    end
  endtask

  task automatic model_halt();
    foreach (ring_q[i]) sb_q.push_back(ring_q[i]);
    ring_q.delete();
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic  prev_stall = 1'b0;
  beat_t prev_beat;
  logic [CNT_W-1:0] prev_cnt;
  beat_t exp_b;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && o_out_valid) begin
        chk("hold_seq", o_out_seq, prev_beat.seq);
        chk("hold_pc", o_out_pc, prev_beat.pc);
        chk("hold_count", o_count, prev_cnt);
      end
      if (o_out_valid && i_out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got seq 0x%0h expected no beat", o_out_seq);
        end else begin
          exp_b = sb_q.pop_front();
          chk("dump_seq", o_out_seq, exp_b.seq);
          chk("dump_pc", o_out_pc, exp_b.pc);
          chk("dump_instr", o_out_instr, exp_b.instr);
        end
      end
      prev_stall = o_out_valid && !i_out_ready;
      prev_beat  = {o_out_seq, o_out_pc, o_out_instr};
      prev_cnt   = o_count;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst = 1'b1;
    i_commit_valid = 1'b0;
    i_halt = 1'b0;
    i_out_ready = 1'b0;
    model_clear();
    tick();
    tick();
    chk("rst_valid", o_out_valid, 0);
    chk("rst_count", o_count, 0);
    chk("rst_ovf", o_overflow_cnt, 0);
    chk("rst_done", o_dump_done, 0);
    chk("rst_out_seq", o_out_seq, 0);
    chk("rst_out_pc", o_out_pc, 0);
    rst = 1'b0;
  endtask

  task automatic commit_one(input logic [31:0] pc, input logic [31:0] instr, input bit with_halt);
    i_commit_valid = 1'b1;
    i_commit_pc    = pc;
    i_commit_instr = instr;
    i_halt         = with_halt;
    tick();
    i_commit_valid = 1'b0;
    i_halt         = 1'b0;
    model_commit(pc, instr);
    chk("count_after_commit", o_count, ring_q.size());
    chk("ovf_after_commit", o_overflow_cnt, m_ovf);
    if (with_halt) model_halt();
  endtask

  task automatic halt_only();
    i_halt = 1'b1;
    tick();
    i_halt = 1'b0;
    model_halt();
    chk("count_at_halt", o_count, sb_q.size());
  endtask

  task automatic run_dump(input int ready_pct, input bit inject);
    int budget = 200;
    while (!o_dump_done && budget > 0) begin
      i_out_ready    = ($urandom_range(99) < ready_pct);
      i_commit_valid = inject && ($urandom_range(1) == 1);
      i_commit_pc    = $urandom;
      i_commit_instr = $urandom;
      i_halt         = inject && ($urandom_range(1) == 1);
      tick();
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL dump_timeout: got dump_done 0 expected 1 within 200 cycles");
    end
    // DONE must ignore everything but reset.
    for (int k = 0; k < 3; k++) begin
      i_out_ready = 1'b1;
      i_commit_valid = 1'b1;
      i_halt = 1'b1;
      tick();
    end
    i_out_ready = 1'b0;
    i_commit_valid = 1'b0;
    i_halt = 1'b0;
    chk("sb_drained", sb_q.size(), 0);
    chk("done_flag", o_dump_done, 1);
    chk("done_count", o_count, 0);
    chk("done_valid", o_out_valid, 0);
    chk("done_out_seq", o_out_seq, 0);
    chk("done_ovf", o_overflow_cnt, m_ovf);
  endtask

  logic [31:0] s_seq;
  logic [CNT_W-1:0] s_cnt;

  initial begin
    rst = 1'b1;
    i_commit_valid = 1'b0;
    i_commit_pc = '0;
    i_commit_instr = '0;
    i_halt = 1'b0;
    i_out_ready = 1'b0;

    // Basic three-commit dump.
    do_reset();
    commit_one(32'h8000_0000, 32'h0000_0413, 0);
    commit_one(32'h8000_0004, 32'h0010_0073, 0);
    commit_one(32'h8000_0008, 32'h0000_0513, 0);
    halt_only();
    run_dump(100, 0);

    // Overflow: six commits into a four-entry ring.
    do_reset();
    for (int k = 0; k < 6; k++) commit_one(32'h8000_0000 + 32'(4 * k), 32'h13 + 32'(k), 0);
    chk("ovf_six", o_overflow_cnt, 2);
    halt_only();
    chk("first_seq_after_ovf", o_out_seq, 2);
    chk("first_pc_after_ovf", o_out_pc, 32'h8000_0008);
    run_dump(100, 0);

    // Backpressure mid-dump.
    do_reset();
    for (int k = 0; k < 4; k++) commit_one($urandom, $urandom, 0);
    halt_only();
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    tick();
    s_seq = o_out_seq;
    s_cnt = o_count;
    tick();
    tick();
    chk("bp_seq", o_out_seq, s_seq);
    chk("bp_count", o_count, s_cnt);
    run_dump(100, 0);

    // Commit in halt cycle, commits during dump, and empty-ring halt.
    do_reset();
    commit_one(32'h100, 32'h1, 0);
    commit_one(32'h104, 32'h2, 1);
    run_dump(60, 1);
    do_reset();
    halt_only();
    run_dump(100, 0);

    // Reset mid-dump.
    do_reset();
    for (int k = 0; k < 3; k++) commit_one(32'h200 + 32'(4 * k), $urandom, 0);
    halt_only();
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    rst = 1'b1;
    model_clear();
    tick();
    chk("mid_rst_count", o_count, 0);
    chk("mid_rst_valid", o_out_valid, 0);
    chk("mid_rst_done", o_dump_done, 0);
    rst = 1'b0;
    commit_one(32'h300, 32'h33, 0);
    halt_only();
    chk("post_rst_seq", o_out_seq, 0);
    run_dump(100, 0);

    // Randomised sessions.
    for (int it = 0; it < 25; it++) begin
      do_reset();
      for (int k = 0; k < int'($urandom_range(9)); k++) begin
        if ($urandom_range(2) == 0) tick();
        commit_one($urandom, $urandom, 0);
      end
      if ($urandom_range(1) == 1) commit_one($urandom, $urandom, 1);
      else halt_only();
      run_dump(30 + int'($urandom_range(70)), 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
